// File: rtl/timer16_responder.sv
// 16-bit programmable down-counter timer answering the MINX bus in an 8-byte window.
// Produces one-cycle underflow and compare pulses for the interrupt block.
module timer16_responder #(
  parameter logic [23:0] BASE     = 24'h2030,
  parameter int          PSC_BITS = 14
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bus_write,
  input  logic        bus_read,
  input  logic [23:0] bus_address_in,
  input  logic [7:0]  bus_data_in,
  output logic [7:0]  bus_data_out,
  output logic        irq_underflow,
  output logic        irq_compare
);

  logic                r_en;
  logic                r_oneshot;
  logic [2:0]          r_sel;
  logic [15:0]         r_preset;
  logic [15:0]         r_cmp;
  logic [15:0]         r_count;
  logic [PSC_BITS-1:0] r_psc;
  logic [7:0]          r_shadow;
  logic                r_read_d;
  logic                r_irq_uf;
  logic                r_irq_cmp;

  logic                w_hit;
  logic [2:0]          w_off;
  logic                w_wr;
  logic                w_ctrl_wr;
  logic [PSC_BITS-1:0] w_div_m1;
  logic                w_tick;
  logic [15:0]         w_count_dec;
  logic                w_rd_start;
  logic [15:0]         w_count_nxt;
  logic                w_en_nxt;
  logic                w_uf_nxt;
  logic                w_cmp_nxt;
  logic [PSC_BITS-1:0] w_psc_nxt;
  logic [7:0]          w_rdata;
  logic                w_unused;

  assign w_hit       = (bus_address_in[23:3] == BASE[23:3]);
  assign w_off       = bus_address_in[2:0];
  assign w_wr        = bus_write & w_hit;
  assign w_ctrl_wr   = w_wr & (w_off == 3'd0);
  // divisor-1 is a run of 2*SEL ones
  assign w_div_m1    = ~({PSC_BITS{1'b1}} << {r_sel, 1'b0});
  assign w_tick      = r_en & (r_psc == w_div_m1);
  assign w_count_dec = r_count - 16'd1;
  assign w_rd_start  = bus_read & ~r_read_d;
  assign w_unused    = ^{bus_data_in[7], bus_data_in[3]};

  assign irq_underflow = r_irq_uf;
  assign irq_compare   = r_irq_cmp;

  always_comb begin
    w_count_nxt = r_count;
    w_en_nxt    = r_en;
    w_uf_nxt    = 1'b0;
    w_cmp_nxt   = 1'b0;
    if (w_ctrl_wr) begin
      w_en_nxt = bus_data_in[0];
    end else begin
      w_en_nxt = r_en;
    end
    // a CTRL write with RELOAD or EN=0 swallows this cycle's tick
    if (w_ctrl_wr && bus_data_in[1]) begin
      w_count_nxt = r_preset;
    end else if (w_ctrl_wr && !bus_data_in[0]) begin
      w_count_nxt = r_count;
    end else if (w_tick) begin
      if (r_count == 16'd0) begin
        w_count_nxt = r_preset;
        w_uf_nxt    = 1'b1;
        if (r_oneshot && !w_ctrl_wr) begin
          w_en_nxt = 1'b0;
        end else begin
          w_en_nxt = w_en_nxt;
        end
      end else begin
        w_count_nxt = w_count_dec;
        w_cmp_nxt   = (w_count_dec == r_cmp);
      end
    end else begin
      w_count_nxt = r_count;
    end
  end

  always_comb begin
    w_psc_nxt = r_psc + PSC_BITS'(1);
    if (!r_en || w_ctrl_wr || w_tick) begin
      w_psc_nxt = '0;
    end else begin
      w_psc_nxt = r_psc + PSC_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en      <= 1'b0;
      r_oneshot <= 1'b0;
      r_sel     <= 3'd0;
      r_preset  <= 16'd0;
      r_cmp     <= 16'd0;
      r_count   <= 16'd0;
      r_psc     <= '0;
      r_shadow  <= 8'd0;
      r_read_d  <= 1'b0;
      r_irq_uf  <= 1'b0;
      r_irq_cmp <= 1'b0;
    end else begin
      r_en      <= w_en_nxt;
      r_count   <= w_count_nxt;
      r_psc     <= w_psc_nxt;
      r_irq_uf  <= w_uf_nxt;
      r_irq_cmp <= w_cmp_nxt;
      r_read_d  <= bus_read;
      if (w_rd_start && w_hit && (w_off == 3'd4)) begin
        r_shadow <= r_count[15:8];
      end
      if (w_wr) begin
        case (w_off)
          3'd0: begin
            r_oneshot <= bus_data_in[2];
            r_sel     <= bus_data_in[6:4];
          end
          3'd2:    r_preset[7:0]  <= bus_data_in;
          3'd3:    r_preset[15:8] <= bus_data_in;
          3'd6:    r_cmp[7:0]     <= bus_data_in;
          3'd7:    r_cmp[15:8]    <= bus_data_in;
          default: r_cmp          <= r_cmp;
        endcase
      end
    end
  end

  always_comb begin
    w_rdata = 8'h00;
    if (bus_read && w_hit) begin
      case (w_off)
        3'd0:    w_rdata = {1'b0, r_sel, 1'b0, r_oneshot, 1'b0, r_en};
        3'd2:    w_rdata = r_preset[7:0];
        3'd3:    w_rdata = r_preset[15:8];
        3'd4:    w_rdata = r_count[7:0];
        3'd5:    w_rdata = r_shadow;
        3'd6:    w_rdata = r_cmp[7:0];
        3'd7:    w_rdata = r_cmp[15:8];
        default: w_rdata = 8'h00;
      endcase
    end else begin
      w_rdata = 8'h00;
    end
  end

  assign bus_data_out = w_rdata;

endmodule
